// File: rtl/aes_sched.sv
// aes_sched: sequencer and round-robin arbiter for an iterative AES-128 round
// datapath. Owns the state, round-key and round-counter registers. Two
// requesters share the datapath. Results return with source index and tag.
// Optional build macro AES_SCHED_ABORT_EN adds a per-requester abort input.
module aes_sched #(
  parameter int ID_W       = 1,
  parameter int NUM_ROUNDS = 10
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [127:0]    req_plaintext0,
  input  logic [127:0]    req_plaintext1,
  input  logic [127:0]    req_key0,
  input  logic [127:0]    req_key1,
  input  logic [ID_W-1:0] req_id0,
  input  logic [ID_W-1:0] req_id1,
  output logic [127:0]    dp_state,
  output logic [127:0]    dp_round_key,
  output logic [3:0]      dp_round,
  output logic            dp_final,
  input  logic [127:0]    dp_next_key,
  input  logic [127:0]    dp_next_state,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [127:0]    res_cipher,
  output logic            res_src,
  output logic [ID_W-1:0] res_id,
  output logic            busy
`ifdef AES_SCHED_ABORT_EN
  ,
  input  logic [1:0]      abort
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  state_t          fsm;
  logic            ptr;
  logic            kill;
  logic            live;
  logic [1:0]      grant;
  logic            sel;
  logic [127:0]    sel_pt;
  logic [127:0]    sel_key;
  logic [ID_W-1:0] sel_id;

  // Grant logic: one-hot accept, live in IDLE and on the DONE handshake cycle
  always_comb begin
    kill = 1'b0;
`ifdef AES_SCHED_ABORT_EN
    kill = (fsm != IDLE) && abort[res_src];
`endif
    live  = !kill && ((fsm == IDLE) || ((fsm == DONE) && res_ready));
    grant = '0;
    if (live) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
    sel     = grant[1];
    sel_pt  = sel ? req_plaintext1 : req_plaintext0;
    sel_key = sel ? req_key1 : req_key0;
    sel_id  = sel ? req_id1 : req_id0;
  end

  assign req_ready = grant;
  assign dp_final  = (dp_round == LAST_ROUND);
  assign busy      = (fsm != IDLE);

  // Sequencer: accept, iterate rounds, hold result until consumed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm          <= IDLE;
      ptr          <= 1'b0;
      dp_state     <= '0;
      dp_round_key <= '0;
      dp_round     <= '0;
      res_valid    <= 1'b0;
      res_cipher   <= '0;
      res_src      <= 1'b0;
      res_id       <= '0;
    end else if (kill) begin
      fsm       <= IDLE;
      res_valid <= 1'b0;
      dp_state  <= '0;
      dp_round  <= '0;
    end else if (|grant) begin
      // Covers both the IDLE accept and the back-to-back accept out of DONE
      fsm          <= ROUND;
      ptr          <= ~sel;
      dp_state     <= sel_pt ^ sel_key;
      dp_round_key <= sel_key;
      dp_round     <= 4'd1;
      res_valid    <= 1'b0;
      res_src      <= sel;
      res_id       <= sel_id;
    end else begin
      case (fsm)
        ROUND: begin
          dp_state     <= dp_next_state;
          dp_round_key <= dp_next_key;
          if (dp_round == LAST_ROUND) begin
            res_cipher <= dp_next_state;
            res_valid  <= 1'b1;
            dp_round   <= '0;
            fsm        <= DONE;
          end else begin
            dp_round <= dp_round + 4'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// tb_aes_sched: directed bench for aes_sched. Supplies a reference AES round
// datapath, keeps a behavioural model of the scheduler, checks every cycle,
// and pins the model with FIPS-197 known-answer vectors.
module tb_aes_sched;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_plaintext0, req_plaintext1, req_key0, req_key1;
  logic [0:0]   req_id0, req_id1;
  logic [127:0] dp_state, dp_round_key, dp_next_key, dp_next_state;
  logic [3:0]   dp_round;
  logic         dp_final;
  logic         res_valid, res_ready;
  logic [127:0] res_cipher;
  logic         res_src;
  logic [0:0]   res_id;
  logic         busy;
`ifdef AES_SCHED_ABORT_EN
  logic [1:0]   abort;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [127:0] q_cipher[$];
  logic         q_src[$];
  logic         q_id[$];
  int           q_cyc[$];

  aes_sched #(.ID_W(1), .NUM_ROUNDS(10)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext0(req_plaintext0), .req_plaintext1(req_plaintext1),
    .req_key0(req_key0), .req_key1(req_key1),
    .req_id0(req_id0), .req_id1(req_id1),
    .dp_state(dp_state), .dp_round_key(dp_round_key),
    .dp_round(dp_round), .dp_final(dp_final),
    .dp_next_key(dp_next_key), .dp_next_state(dp_next_state),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_cipher(res_cipher), .res_src(res_src), .res_id(res_id),
    .busy(busy)
`ifdef AES_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] kexp(input logic [127:0] k, input logic [3:0] rnd);
    logic [31:0] w3, rot, t;
    logic [31:0] n0, n1, n2, n3;
    logic [7:0]  rc;
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    rc  = 8'h01;
    for (int i = 1; i < int'(rnd); i++) rc = xt(rc);
    t  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
         ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   t[16];
    logic [7:0]   u[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        u[r+4*c] = t[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        u[4*c]   = xt(a0) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        u[4*c+1] = a0 ^ xt(a1) ^ gmul(a2, 8'h03) ^ a3;
        u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ gmul(a3, 8'h03);
        u[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ xt(a3);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = u[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 1; r <= 10; r++) begin
      k = kexp(k, 4'(r));
      s = aes_round(s, k, r == 10);
    end
    return s;
  endfunction

  // Round datapath driven back into the scheduler
  always_comb begin
    dp_next_key   = kexp(dp_round_key, dp_round);
    dp_next_state = aes_round(dp_state, dp_next_key, dp_final);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural scheduler model ----------------
  int           m_phase;   // 0 idle, 1 computing, 2 result waiting
  int           m_round;
  logic         m_ptr;
  logic [127:0] m_cipher, m_init, m_key;
  logic         m_src;
  logic [0:0]   m_id;
  logic         m_kill;
  logic [1:0]   m_grant;
  logic         m_w;

  function automatic logic [1:0] pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Per-cycle compare against the model, then advance the model to the next edge
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dp_round", dp_round, 0);
      chk("rst_dp_state", dp_state, 0);
      chk("rst_dp_round_key", dp_round_key, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_cipher", res_cipher, 0);
      chk("rst_res_src", res_src, 0);
      chk("rst_res_id", res_id, 0);
      m_phase = 0;
      m_round = 0;
      m_ptr   = 1'b0;
      m_src   = 1'b0;
    end else begin
      m_kill = 1'b0;
`ifdef AES_SCHED_ABORT_EN
      m_kill = (m_phase != 0) && abort[m_src];
`endif
      m_grant = '0;
      if (!m_kill && (m_phase == 0 || (m_phase == 2 && res_ready)))
        m_grant = pick(req_valid, m_ptr);
      chk("req_ready", req_ready, m_grant);
      chk("busy", busy, m_phase != 0);
      chk("dp_round", dp_round, (m_phase == 1) ? m_round : 0);
      chk("dp_final", dp_final, (m_phase == 1) && (m_round == 10));
      chk("res_valid", res_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("res_cipher", res_cipher, m_cipher);
        chk("res_src", res_src, m_src);
        chk("res_id", res_id, m_id);
      end
      if (m_phase == 1 && m_round == 1) begin
        chk("dp_state_init", dp_state, m_init);
        chk("dp_round_key_init", dp_round_key, m_key);
      end
      if (res_valid && res_ready) begin
        q_cipher.push_back(res_cipher);
        q_src.push_back(res_src);
        q_id.push_back(res_id);
        q_cyc.push_back(cyc);
      end
      if (m_kill) begin
        m_phase = 0;
        m_round = 0;
      end else if (m_grant != 2'b00) begin
        m_w      = m_grant[1];
        m_key    = m_w ? req_key1 : req_key0;
        m_init   = (m_w ? req_plaintext1 : req_plaintext0) ^ m_key;
        m_cipher = aes_enc(m_w ? req_plaintext1 : req_plaintext0, m_key);
        m_src    = m_w;
        m_id     = m_w ? req_id1 : req_id0;
        m_ptr    = !m_w;
        m_phase  = 1;
        m_round  = 1;
      end else if (m_phase == 1) begin
        if (m_round == 10) begin
          m_phase = 2;
          m_round = 0;
        end else begin
          m_round++;
        end
      end else if (m_phase == 2 && res_ready) begin
        m_phase = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    q_cipher.delete();
    q_src.delete();
    q_id.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_result(output int k);
    k = 0;
    while (!res_valid && k < 60) begin
      tick();
      k++;
    end
  endtask

  task automatic chk_q(input string nm, input int idx, input logic [127:0] ct, input logic src);
    if (idx < q_src.size()) begin
      chk({nm, "_cipher"}, q_cipher[idx], ct);
      chk({nm, "_src"}, q_src[idx], src);
      chk({nm, "_id"}, q_id[idx], src);
    end else begin
      chk({nm, "_present"}, 0, 1);
    end
  endtask

  int k;
  int n;

  initial begin
    reset_n        = 1'b0;
    req_valid      = 2'b00;
    res_ready      = 1'b1;
    req_plaintext0 = PT_A;
    req_key0       = KEY_A;
    req_id0        = 1'b0;
    req_plaintext1 = PT_B;
    req_key1       = KEY_B;
    req_id1        = 1'b1;
`ifdef AES_SCHED_ABORT_EN
    abort = 2'b00;
`endif
    chk("pin_model_A", aes_enc(PT_A, KEY_A), CT_A);
    chk("pin_model_B", aes_enc(PT_B, KEY_B), CT_B);

    // REQ0 alone: latency and known-answer ciphertext
    do_reset();
    clear_q();
    req_valid = 2'b01;
    #1 chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    wait_result(k);
    chk("t1_latency", k, 10);
    tick();
    chk("t1_count", q_src.size(), 1);
    chk_q("t1", 0, CT_A, 1'b0);

    // REQ1 alone with tag 1
    clear_q();
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_result(k);
    chk("t2_latency", k, 10);
    tick();
    chk("t2_count", q_src.size(), 1);
    chk_q("t2", 0, CT_B, 1'b1);

    // Both requesters continuously valid from reset: alternation, 11-cycle spacing
    do_reset();
    clear_q();
    req_valid = 2'b11;
    n = 0;
    while (q_src.size() < 4 && n < 200) begin
      tick();
      n++;
    end
    req_valid = 2'b00;
    chk_q("t3_r0", 0, CT_A, 1'b0);
    chk_q("t3_r1", 1, CT_B, 1'b1);
    chk_q("t3_r2", 2, CT_A, 1'b0);
    chk_q("t3_r3", 3, CT_B, 1'b1);
    for (int i = 1; i < 4; i++)
      if (i < q_cyc.size()) chk("t3_gap", q_cyc[i] - q_cyc[i-1], 11);
    n = 0;
    while ((busy || res_valid) && n < 60) begin
      tick();
      n++;
    end
    chk("t3_drained", busy, 0);

    // Consumer stall for 20 cycles with REQ1 pending
    clear_q();
    res_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    wait_result(k);
    chk("t4_valid", res_valid, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_cipher", res_cipher, CT_A);
      chk("t4_hold_src", res_src, 0);
      chk("t4_hold_ready", req_ready, 2'b00);
    end
    chk("t4_none_yet", q_src.size(), 0);
    res_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    chk("t4_next_busy", busy, 1);
    wait_result(k);
    tick();
    chk("t4_count", q_src.size(), 2);
    chk_q("t4_first", 0, CT_A, 1'b0);
    chk_q("t4_second", 1, CT_B, 1'b1);

    // Asynchronous reset at dp_round 5
    clear_q();
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    n = 0;
    while (dp_round != 4'd5 && n < 30) begin
      tick();
      n++;
    end
    chk("t5_round5", dp_round, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_round", dp_round, 0);
    chk("t5_async_state", dp_state, 0);
    chk("t5_async_cipher", res_cipher, 0);
    tick();
    reset_n = 1'b1;
    chk("t5_no_result", q_src.size(), 0);
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    wait_result(k);
    chk("t5_latency", k, 10);
    tick();
    chk("t5_count", q_src.size(), 1);
    chk_q("t5", 0, CT_A, 1'b0);

`ifdef AES_SCHED_ABORT_EN
    // Abort REQ0 job at round 3; pending REQ1 completes afterwards
    do_reset();
    clear_q();
    req_valid = 2'b11;
    tick();
    req_valid = 2'b10;
    n = 0;
    while (dp_round != 4'd3 && n < 30) begin
      tick();
      n++;
    end
    abort = 2'b01;
    tick();
    abort = 2'b00;
    chk("t6_idle", busy, 0);
    chk("t6_state_clr", dp_state, 0);
    chk("t6_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_result(k);
    tick();
    chk("t6_count", q_src.size(), 1);
    chk_q("t6", 0, CT_B, 1'b1);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_sched.md
Name: aes_sched

Overview:
- Sequencer and arbiter for the iterative AES-128 round datapath: subBytes, shiftRows, MixColumns and keyExpand.
- Owns the state register, round-key register and round counter, and drives the combinational round logic once per cycle.
- Shares the single datapath between two requesters (REQ0, REQ1) using round-robin arbitration.
- Returns each ciphertext with a requester tag over a valid/ready handshake.

Parameters:
- ID_W, 1, width of the per-request user tag echoed back with the result.
- NUM_ROUNDS, 10, number of AES rounds; the round counter width is fixed at 4 bits.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit r belongs to requester r.
- req_ready  out  2  per-requester accept; bit r belongs to requester r.
- req_plaintext0 / req_plaintext1  in  128  plaintext block.
- req_key0 / req_key1  in  128  cipher key.
- req_id0 / req_id1  in  ID_W  user tag.
- dp_state  out  128  current state register, driven to the round logic.
- dp_round_key  out  128  current round-key register.
- dp_round  out  4  current round number, 1..NUM_ROUNDS; 0 when idle.
- dp_final  out  1  high when dp_round==NUM_ROUNDS; tells the datapath to skip MixColumns.
- dp_next_key  in  128  combinational keyExpand(dp_round_key, dp_round).
- dp_next_state  in  128  combinational round result using dp_next_key.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_cipher  out  128  ciphertext.
- res_src  out  1  requester index that owns the result.
- res_id  out  ID_W  echoed tag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State machine = IDLE; the state register, key register, dp_round, res_cipher and res_id are all 0.
  - res_valid=0, res_src=0, busy=0, req_ready=2'b00.
  - Round-robin priority pointer = 0, so REQ0 is preferred first.
- States and transitions:
  - IDLE -> ROUND, DONE -> IDLE (or DONE -> ROUND on back-to-back, below).
  - IDLE: req_ready is a one-hot grant, combinational from req_valid and the pointer.
    - Only one request is accepted per cycle.
    - If both requesters are valid, the requester the pointer selects wins, and the pointer then moves to the other requester.
    - If exactly one is valid, it wins and the pointer moves past it.
  - On accept (req_valid[r] & req_ready[r]):
    - state register <= plaintext ^ key; key register <= key; dp_round <= 1.
    - Capture src and id; go to ROUND.
  - ROUND: each cycle, state register <= dp_next_state, key register <= dp_next_key, dp_round <= dp_round+1.
    - When dp_round==NUM_ROUNDS: res_cipher <= dp_next_state, res_valid <= 1, dp_round <= 0, go to DONE.
  - DONE: res_valid, res_cipher, res_src and res_id are held stable until res_ready is high.
    - On res_valid & res_ready, go to IDLE.
    - In that same cycle the grant logic is live: req_ready may assert and the next request is accepted directly into ROUND (back-to-back, no IDLE bubble).
- Latency:
  - Accept edge at cycle 0; res_valid high after edge NUM_ROUNDS (edge 10).
  - Throughput is one block per 11 cycles when the consumer is always ready.
- Handshake rules:
  - req_ready is 0 throughout ROUND, and in DONE unless res_ready=1.
  - Requester inputs are sampled only on the accept edge; later changes are ignored.
  - A requester may drop req_valid before it is granted without penalty.
- Boundary conditions:
  - Simultaneous requests: arbitrate as above. A losing request stays pending and must be granted next.
  - res_ready held low indefinitely: the block stalls in DONE and no request is lost.
  - Reset mid-operation: return to reset values immediately, with no result emitted.
  - dp_round never exceeds NUM_ROUNDS and never wraps.

Optional Feature:
- Macro: AES_SCHED_ABORT_EN.
- When defined, add port abort (in, 2).
  - If abort[res_src] is high during ROUND or DONE, the block returns to IDLE on the next edge.
  - res_valid is forced to 0 and the state register is cleared to 0; the pointer is not altered.
  - abort for the non-owning requester is ignored.
- When undefined, there is no abort port and the block behaves exactly as described above.

Test Plan:
- REQ0 alone, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, bench reference datapath -> res_valid at edge 10, cipher 69c4e0d86a7b0430d8cdb78070b4c55a, res_src=0.
- REQ1 alone, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, id=1 -> cipher 3925841d02dc09fbdc118597196a0b32, res_src=1, res_id=1.
- Both requesters valid continuously from reset -> grants alternate 0,1,0,1; consecutive results arrive 11 cycles apart with no idle gap.
- res_ready low for 20 cycles after res_valid -> cipher and tag stable, req_ready=00 throughout; ciphertext delivered when res_ready rises.
- reset_n pulsed low at dp_round=5 -> all outputs return to reset values asynchronously; no res_valid; the next request completes correctly.
- With AES_SCHED_ABORT_EN, abort[0] at dp_round=3 on a REQ0 job -> IDLE next edge, no result; a pending REQ1 job then completes normally.
